// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: the signals between the stall/flush scheduler and the
// rest of the pipeline.
//   Hazard and status inputs : data_hazard, EX_br_taken, MEM_mem_req,
//                              MEM_mem_ready, WB_halt
//   Register write enables   : pc_we, IFID_we, IDEX_we, EXMEM_we
//   Bubble-insert controls   : IFID_flush, IDEX_flush, MEMWB_flush
//   Status                   : mem_err (timeout strobe), ctrl_state,
//                              stall_cnt, flush_cnt (CNT_W bits)
// The master modport drives the hazard/status inputs.
// The slave modport is the controller itself.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             data_hazard;
  logic             EX_br_taken;
  logic             MEM_mem_req;
  logic             MEM_mem_ready;
  logic             WB_halt;
  logic             pc_we;
  logic             IFID_we;
  logic             IDEX_we;
  logic             EXMEM_we;
  logic             IFID_flush;
  logic             IDEX_flush;
  logic             MEMWB_flush;
  logic             mem_err;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output data_hazard, EX_br_taken, MEM_mem_req, MEM_mem_ready, WB_halt,
    input  pc_we, IFID_we, IDEX_we, EXMEM_we,
    input  IFID_flush, IDEX_flush, MEMWB_flush,
    input  mem_err, ctrl_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  data_hazard, EX_br_taken, MEM_mem_req, MEM_mem_ready, WB_halt,
    output pc_we, IFID_we, IDEX_we, EXMEM_we,
    output IFID_flush, IDEX_flush, MEMWB_flush,
    output mem_err, ctrl_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush scheduler for the 5-stage pipeline.
// The block turns these inputs into per-register write-enable and flush
// controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB:
//   - the load-use hazard
//   - the EX redirect
//   - the data-memory handshake
//   - the WB halt
// The controls are Mealy outputs: they are valid in the same cycle as the
// inputs that cause them.
// The FSM has three states:
//   - RUN
//   - MEM_WAIT: tracks multi-cycle memory stalls with an optional timeout
//   - HALTED: sticky until reset
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  pipeline_ctrl_if slave: hazard inputs, write enables, flushes,
//        mem_err, ctrl_state, stall_cnt, flush_cnt
// Parameters:
//   MEM_TIMEOUT  maximum frozen cycles per memory access (0 = no timeout)
//   CNT_W        width of the saturating performance counters
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic pc_we, ifid_we, idex_we, exmem_we;
  logic ifid_flush, idex_flush, memwb_flush;
  logic mem_err;
  logic mem_stall, timed_out;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + WAIT_W'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_we     = 1'b0;
    exmem_we    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    mem_err     = 1'b0;

    mem_stall = bus.MEM_mem_req & ~bus.MEM_mem_ready;
    // The timeout fires only once MEM_WAIT has already counted
    // MEM_TIMEOUT frozen cycles. That cycle is then released as if
    // the memory were ready.
    timed_out = (MEM_TIMEOUT != 0) && (state_q == ST_MEM_WAIT) &&
                mem_stall && (wait_cnt_q == TIMEOUT_V);

    if (rst) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      state_d     = ST_RUN;
      wait_cnt_d  = '0;
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      case (state_q)
        ST_HALTED: begin
          // Everything is held and every input is ignored until reset.
        end
        default: begin
          if (bus.WB_halt) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
            state_d     = ST_HALTED;
            wait_cnt_d  = '0;
          end else if (mem_stall && !timed_out) begin
            // Freeze the whole front end. A pending EX redirect stays
            // latched in EX and is acted on in the release cycle.
            memwb_flush = 1'b1;
            stall_cnt_d = sat_inc_cnt(stall_cnt_q);
            if (state_q == ST_MEM_WAIT) begin
              wait_cnt_d = sat_inc_wait(wait_cnt_q);
            end else begin
              state_d    = ST_MEM_WAIT;
              wait_cnt_d = WAIT_W'(1);
            end
          end else begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
            mem_err    = timed_out;
            if (bus.EX_br_taken) begin
              pc_we       = 1'b1;
              ifid_we     = 1'b1;
              idex_we     = 1'b1;
              exmem_we    = 1'b1;
              ifid_flush  = 1'b1;
              idex_flush  = 1'b1;
              flush_cnt_d = sat_inc_cnt(flush_cnt_q);
            end else if (bus.data_hazard) begin
              // Hold PC and IF/ID; push a bubble into ID/EX.
              idex_we     = 1'b1;
              exmem_we    = 1'b1;
              idex_flush  = 1'b1;
              stall_cnt_d = sat_inc_cnt(stall_cnt_q);
            end else begin
              pc_we    = 1'b1;
              ifid_we  = 1'b1;
              idex_we  = 1'b1;
              exmem_we = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_we       = pc_we;
  assign bus.IFID_we     = ifid_we;
  assign bus.IDEX_we     = idex_we;
  assign bus.EXMEM_we    = exmem_we;
  assign bus.IFID_flush  = ifid_flush;
  assign bus.IDEX_flush  = idex_flush;
  assign bus.MEMWB_flush = memwb_flush;
  assign bus.mem_err     = mem_err;
  assign bus.ctrl_state  = state_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed bench for pipeline_ctrl with MEM_TIMEOUT=4 and
// 8-bit counters.
// Each step drives one cycle of inputs and queues the expected controls.
// The expected values are then popped and compared just after the falling
// edge.
module tb_pipeline_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 8;

  // Control vector layout:
  // {pc_we, IFID_we, IDEX_we, EXMEM_we, IFID_flush, IDEX_flush, MEMWB_flush}
  localparam logic [6:0] C_RUN = 7'b1111_000;
  localparam logic [6:0] C_FRZ = 7'b0000_001;
  localparam logic [6:0] C_RED = 7'b1111_110;
  localparam logic [6:0] C_LU  = 7'b0011_010;
  localparam logic [6:0] C_HLT = 7'b0000_111;
  localparam logic [6:0] C_HLD = 7'b0000_000;
  localparam logic [6:0] C_RST = 7'b0000_111;

  typedef struct {
    string      tag;
    logic [6:0] ctl;
    logic       err;
    logic [1:0] st;
    int         sc;
    int         fc;
  } exp_t;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  exp_t sb_q[$];

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what,
                     input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s.%s got=%0h expected=%0h", tag, what, got, exp);
  endtask

  // One cycle: drive inputs after the falling edge, queue the expectation,
  // let the combinational outputs settle, then pop and compare.
  task automatic step(input string tag,
                      input logic dh, input logic br, input logic req,
                      input logic rdy, input logic halt, input logic r,
                      input logic [6:0] ctl, input logic err,
                      input logic [1:0] st, input int sc, input int fc);
    exp_t e;
    exp_t got_e;
    logic [6:0] ctl_obs;
    @(negedge clk);
    bus.data_hazard   = dh;
    bus.EX_br_taken   = br;
    bus.MEM_mem_req   = req;
    bus.MEM_mem_ready = rdy;
    bus.WB_halt       = halt;
    rst               = r;
    e.tag = tag; e.ctl = ctl; e.err = err; e.st = st; e.sc = sc; e.fc = fc;
    sb_q.push_back(e);
    #1;
    if (sb_q.size() == 0) begin
      n_total++;
      $error("FAIL %s.scoreboard got=empty expected=entry", tag);
    end else begin
      got_e   = sb_q.pop_front();
      ctl_obs = {bus.pc_we, bus.IFID_we, bus.IDEX_we, bus.EXMEM_we,
                 bus.IFID_flush, bus.IDEX_flush, bus.MEMWB_flush};
      chk(got_e.tag, "ctl",   32'(ctl_obs),        32'(got_e.ctl));
      chk(got_e.tag, "err",   32'(bus.mem_err),    32'(got_e.err));
      chk(got_e.tag, "state", 32'(bus.ctrl_state), 32'(got_e.st));
      chk(got_e.tag, "stall", 32'(bus.stall_cnt),  32'(got_e.sc));
      chk(got_e.tag, "flush", 32'(bus.flush_cnt),  32'(got_e.fc));
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    bus.data_hazard   = 1'b0;
    bus.EX_br_taken   = 1'b0;
    bus.MEM_mem_req   = 1'b0;
    bus.MEM_mem_ready = 1'b0;
    bus.WB_halt       = 1'b0;
    @(posedge clk);

    //    tag        dh   br   req  rdy  hlt  rst   ctl    err  st  sc fc
    step("reset",    0,   0,   0,   0,   0,   1,    C_RST, 0,   0,  0, 0);
    step("idle0",    0,   0,   0,   0,   0,   0,    C_RUN, 0,   0,  0, 0);

    // Memory wait: three not-ready cycles, then ready.
    step("mw1",      0,   0,   1,   0,   0,   0,    C_FRZ, 0,   0,  0, 0);
    step("mw2",      0,   0,   1,   0,   0,   0,    C_FRZ, 0,   1,  1, 0);
    step("mw3",      0,   0,   1,   0,   0,   0,    C_FRZ, 0,   1,  2, 0);
    step("mw_rel",   0,   0,   1,   1,   0,   0,    C_RUN, 0,   1,  3, 0);
    step("mw_after", 0,   0,   0,   0,   0,   0,    C_RUN, 0,   0,  3, 0);

    // Timeout: ready never arrives.
    step("to1",      0,   0,   1,   0,   0,   0,    C_FRZ, 0,   0,  3, 0);
    step("to2",      0,   0,   1,   0,   0,   0,    C_FRZ, 0,   1,  4, 0);
    step("to3",      0,   0,   1,   0,   0,   0,    C_FRZ, 0,   1,  5, 0);
    step("to4",      0,   0,   1,   0,   0,   0,    C_FRZ, 0,   1,  6, 0);
    step("to_rel",   0,   0,   1,   0,   0,   0,    C_RUN, 1,   1,  7, 0);
    step("to_again", 0,   0,   1,   0,   0,   0,    C_FRZ, 0,   0,  7, 0);
    step("to_done",  0,   0,   1,   1,   0,   0,    C_RUN, 0,   1,  8, 0);
    step("to_idle",  0,   0,   0,   0,   0,   0,    C_RUN, 0,   0,  8, 0);

    // Load-use then redirect.
    step("lu",       1,   0,   0,   0,   0,   0,    C_LU,  0,   0,  8, 0);
    step("lu_red",   0,   1,   0,   0,   0,   0,    C_RED, 0,   0,  9, 0);
    step("lu_idle",  0,   0,   0,   0,   0,   0,    C_RUN, 0,   0,  9, 1);

    // Redirect and hazard together: redirect wins, no stall counted.
    step("both",     1,   1,   0,   0,   0,   0,    C_RED, 0,   0,  9, 1);
    step("both_idl", 0,   0,   0,   0,   0,   0,    C_RUN, 0,   0,  9, 2);

    // Redirect held through a two-cycle memory wait.
    step("def1",     0,   1,   1,   0,   0,   0,    C_FRZ, 0,   0,  9, 2);
    step("def2",     0,   1,   1,   0,   0,   0,    C_FRZ, 0,   1, 10, 2);
    step("def_rel",  0,   1,   1,   1,   0,   0,    C_RED, 0,   1, 11, 2);
    step("def_idle", 0,   0,   0,   0,   0,   0,    C_RUN, 0,   0, 11, 3);

    // Reset in the middle of a memory wait.
    step("rmw1",     0,   0,   1,   0,   0,   0,    C_FRZ, 0,   0, 11, 3);
    step("rmw2",     0,   0,   1,   0,   0,   0,    C_FRZ, 0,   1, 12, 3);
    step("rmw_rst",  0,   0,   1,   0,   0,   1,    C_RST, 0,   1, 13, 3);
    step("rmw_idle", 0,   0,   0,   0,   0,   0,    C_RUN, 0,   0,  0, 0);

    // Halt, ten ignored cycles with busy inputs, then reset.
    step("pre_halt", 1,   0,   0,   0,   0,   0,    C_LU,  0,   0,  0, 0);
    step("halt",     0,   0,   0,   0,   1,   0,    C_HLT, 0,   0,  1, 0);
    for (int i = 0; i < 10; i++) begin
      step("halted", i[0], ~i[0], i[1], 1'b0, i[2], 1'b0,
           C_HLD, 1'b0, 2'd2, 1, 0);
    end
    step("h_rst",    0,   0,   0,   0,   0,   1,    C_RST, 0,   2,  1, 0);
    step("h_idle",   0,   0,   0,   0,   0,   0,    C_RUN, 0,   0,  0, 0);

    // Halt arriving while in MEM_WAIT.
    step("mh1",      0,   0,   1,   0,   0,   0,    C_FRZ, 0,   0,  0, 0);
    step("mh_halt",  0,   0,   1,   0,   1,   0,    C_HLT, 0,   1,  1, 0);
    step("mh_hold",  0,   0,   1,   1,   0,   0,    C_HLD, 0,   2,  1, 0);
    step("mh_rst",   0,   0,   0,   0,   0,   1,    C_RST, 0,   2,  1, 0);
    step("mh_idle",  0,   0,   0,   0,   0,   0,    C_RUN, 0,   0,  0, 0);

    // Counter saturation at 8 bits.
    for (int i = 0; i < 260; i++) begin
      step("sat_stall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           C_LU, 1'b0, 2'd0, (i < 255) ? i : 255, 0);
    end
    for (int i = 0; i < 260; i++) begin
      step("sat_flush", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
           C_RED, 1'b0, 2'd0, 255, (i < 255) ? i : 255);
    end
    step("sat_end",  0,   0,   0,   0,   0,   0,    C_RUN, 0,   0, 255, 255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush scheduler for the 5-stage pipeline. Combines the load-use `data_hazard` flag from hazard detection, the EX-stage redirect, the data-memory handshake and the WB halt into per-register write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. A small FSM (RUN / MEM_WAIT / HALTED) tracks multi-cycle memory stalls with a timeout and a sticky halt. Saturating stall and flush performance counters are included.

## Interface
- MEM_TIMEOUT, 16: max frozen cycles per memory access; 0 disables the timeout.
- CNT_W, 32: width of the performance counters.

- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- data_hazard  in  1  load-use hazard between ID and EX.
- EX_br_taken  in  1  EX-stage branch/jump redirects the PC.
- MEM_mem_req  in  1  MEM-stage load/store access is active.
- MEM_mem_ready  in  1  data memory completes the access this cycle.
- WB_halt  in  1  halting instruction (ebreak) is in WB.
- pc_we, IFID_we, IDEX_we, EXMEM_we  out  1 each  pipeline register write enables.
- IFID_flush, IDEX_flush, MEMWB_flush  out  1 each  load a bubble instead of the upstream value.
- mem_err  out  1  one-cycle timeout strobe.
- ctrl_state  out  2  0=RUN, 1=MEM_WAIT, 2=HALTED.
- stall_cnt  out  CNT_W  stalled-cycle count.
- flush_cnt  out  CNT_W  redirect count.

## Operation
- Outputs are Mealy: current state plus current inputs. State, wait_cnt and the counters are registered.
- **Reset** (rst=1): all `*_we`=0, all `*_flush`=1, mem_err=0. Next state is RUN, wait_cnt=0, both counters=0.
- **Freeze pattern**: pc_we, IFID_we, IDEX_we and EXMEM_we = 0; MEMWB_flush=1; the other flushes are 0.
- **RUN / MEM_WAIT priority, highest first:**
  1. **WB_halt**: all `*_we`=0 and all flushes=1. Next state is HALTED.
  2. **Memory stall** (MEM_mem_req & !MEM_mem_ready), not timed out: freeze pattern and stall_cnt+1.
     - From RUN: go to MEM_WAIT with wait_cnt←1.
     - In MEM_WAIT: wait_cnt+1.
  3. **Redirect** (EX_br_taken): all we=1, IFID_flush=1, IDEX_flush=1, flush_cnt+1.
  4. **Load-use** (data_hazard): pc_we=0, IFID_we=0, IDEX_we=1, EXMEM_we=1, IDEX_flush=1, stall_cnt+1.
  5. **Otherwise**: all we=1, all flushes=0.
- **MEM_WAIT exit**: the cycle with MEM_mem_ready=1 is evaluated by rules 3–5, and the next state is RUN.
- **Timeout**: in MEM_WAIT with !MEM_mem_ready and wait_cnt==MEM_TIMEOUT (MEM_TIMEOUT≠0):
  - mem_err=1 for that cycle.
  - The cycle is treated as ready (rules 3–5 apply) and the next state is RUN.
- **HALTED**: all `*_we`=0, all flushes=0, counters hold. The state is sticky until rst; all inputs are ignored.
- **Redirect during a memory stall**: deferred. EX is frozen, so EX_br_taken stays asserted and is acted on in the release cycle.
- **Redirect together with data_hazard**: redirect wins and stall_cnt does not increment.
- **Counters**: saturate at all-ones and never wrap. Halt and reset cycles are not counted as stalls.
- **Width**: wait_cnt is $clog2(MEM_TIMEOUT+1) bits, minimum 1.

## Timing
- Zero-cycle decision: controls are valid in the same cycle as the inputs that cause them.
- State, wait_cnt and counter updates take effect on the next rising edge.
- A memory access held not-ready for N cycles produces N frozen cycles (N ≤ MEM_TIMEOUT), then one release cycle.
- Load-use costs exactly one stall cycle per asserted cycle of data_hazard.
- A redirect costs two bubbles (IF/ID and ID/EX) and no stall cycle.
- A timeout costs exactly MEM_TIMEOUT frozen cycles, then a release cycle carrying mem_err=1.
- Reset mid-MEM_WAIT or mid-HALTED returns to RUN on the next edge and clears all counters.

## Test plan
- **Memory wait**: MEM_mem_req=1 with MEM_mem_ready low for 3 cycles, then high.
  - Required: 3 freeze cycles with ctrl_state=1 on cycles 2–3.
  - Release cycle has all we=1; stall_cnt=3; ctrl_state=0 afterwards.
- **Timeout** (MEM_TIMEOUT=4): MEM_mem_req=1, MEM_mem_ready=0 forever.
  - Required: 4 freeze cycles; 5th cycle has mem_err=1 and pc_we=1.
  - Next cycle is RUN and stall_cnt=4.
- **Load-use then redirect**: data_hazard=1 for 1 cycle, then EX_br_taken=1 for 1 cycle.
  - Cycle 1: pc_we=0, IFID_we=0, IDEX_flush=1.
  - Cycle 2: pc_we=1, IFID_flush=1, IDEX_flush=1.
  - Final counts: stall_cnt=1, flush_cnt=1.
- **Simultaneous redirect and hazard**: EX_br_taken=1 and data_hazard=1 in the same cycle.
  - Required: redirect controls only; flush_cnt=1, stall_cnt=0.
- **Deferred redirect**: EX_br_taken=1 held through a 2-cycle memory wait.
  - Required: no IDEX_flush during the wait; IFID_flush=IDEX_flush=1 only in the release cycle; flush_cnt=1.
- **Halt and reset**: WB_halt=1, then 10 idle cycles, then rst=1 for 1 cycle.
  - Halt cycle: all flushes=1.
  - Following 10 cycles: ctrl_state=2 and pc_we=0 throughout.
  - After reset: ctrl_state=0, counters=0, all we=1 with idle inputs.
